circuito_decodificador_funcionalidade: RTL and testbench
========================================================

# circuito_decodificador_funcionalidade

Registered decoder that converts the 3-bit functionality code CF back into the seven one-hot select lines A..G and holds the selected line while that functionality runs. It sits at the receiving end of the functionality-encoder path. It accepts a code under a LOAD strobe, drives exactly one select line until the function reports DONE, then returns to idle. An optional timeout watchdog aborts a function that never completes.

## Interface
- TIMEOUT, default 100: maximum number of cycles in ACTIVE before abort; used only with the watchdog compiled in; legal range 2..255.
- clk  input  1  rising-edge clock
- rst  input  1  reset, synchronous, active-high
- LOAD  input  1  request strobe; CF is sampled when LOAD=1 in IDLE
- CF  input  3  functionality code
- DONE  input  1  running function finished; sampled only in ACTIVE
- A, B, C, D, E, F, G  output  1 each  registered one-hot select lines
- BUSY  output  1  high while in ACTIVE
- ACK  output  1  one-cycle pulse: code accepted
- ERR  output  1  one-cycle pulse: invalid code, or watchdog abort

## Operation
- Code map (CF[2:0] -> line): 100->A, 010->B, 110->C, 001->D, 101->E, 011->F, 111->G; 000 is invalid.
- States: IDLE and ACTIVE.
- IDLE:
  - All select lines, BUSY, ACK and ERR are 0, except for the one-cycle pulses defined below.
  - LOAD=1 with a valid CF: latch CF, enter ACTIVE, pulse ACK.
  - LOAD=1 with CF=000: pulse ERR and stay in IDLE. No select line is driven.
  - LOAD=0: no action.
- ACTIVE:
  - Exactly one select line is high, per the latched code. BUSY=1.
  - LOAD and CF are ignored; no ACK and no ERR result from them. The latched code does not change.
  - DONE=1: return to IDLE. All select lines and BUSY clear.
- Watchdog, when compiled in:
  - An 8-bit counter clears on entry to ACTIVE and increments each ACTIVE cycle.
  - If the counter reaches TIMEOUT-1 with DONE=0, return to IDLE and pulse ERR.
  - DONE=1 in the same cycle as the timeout: DONE wins, with no ERR.
- Simultaneous events:
  - A LOAD in the cycle DONE is sampled is ignored. A new request must arrive in IDLE.
  - rst overrides everything.
- Reset: on an rst cycle all outputs go to 0, the state goes to IDLE, the latched code goes to 000 and the counter to 0. This holds mid-ACTIVE too: the select line drops at that same edge.

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- Accept latency: LOAD sampled at edge N -> select line, BUSY and ACK high after edge N. ACK falls after edge N+1.
- Release latency: DONE sampled at edge M -> select line and BUSY low after edge M.
- Minimum ACTIVE duration is 1 cycle (DONE high at the first ACTIVE edge).
- Back-to-back: earliest next accept is the edge after the return to IDLE. Consecutive requests are therefore separated by at least one idle cycle.
- Watchdog abort: with TIMEOUT=T and no DONE, the select line is high for exactly T cycles. ERR is high during the first IDLE cycle.
- ERR for an invalid code: high for the one cycle after the sampling edge.

## Configuration
- Macro: DECOD_FUNC_TIMEOUT_EN.
- Defined: the watchdog counter and the TIMEOUT abort are built as described above.
- Undefined: no counter is built and the TIMEOUT parameter is unused. ACTIVE is left only by DONE or rst, and ERR is driven only by invalid codes.

## Test plan
- Reset, then LOAD=1 with CF=110 for one cycle -> C=1, BUSY=1, ACK=1 one cycle later; all other lines 0. DONE=1 after 5 cycles -> C=0 and BUSY=0 on the next edge.
- Sweep all seven valid codes, each with DONE after 2 cycles -> line order A(100), B(010), C(110), D(001), E(101), F(011), G(111); exactly one line high while ACTIVE.
- LOAD=1 with CF=000 -> ERR high for 1 cycle, all lines 0, BUSY=0, no ACK.
- In ACTIVE on code 011, apply LOAD=1 with CF=100 -> F stays high, A stays 0, no ACK or ERR. Assert rst mid-ACTIVE -> all outputs 0 at that edge.
- With DECOD_FUNC_TIMEOUT_EN and TIMEOUT=4, load 111 and hold DONE=0 -> G high for exactly 4 cycles, then ERR pulses once. Repeat with DONE asserted on the 4th cycle -> clean release, no ERR.
- Without DECOD_FUNC_TIMEOUT_EN, load 001 and hold DONE=0 for 300 cycles -> D stays high and ERR never asserts.

Source files
------------

// File: rtl/circuito_decodificador_funcionalidade.sv
// Registered 3-bit functionality code to one-hot select decoder; holds the line until DONE. Optional watchdog: DECOD_FUNC_TIMEOUT_EN.
// Latency: LOAD/DONE sampled at edge N -> outputs change right after edge N; all outputs registered.
// Backpressure: LOAD is ignored while BUSY; requesters must wait for BUSY low before the next LOAD.
module circuito_decodificador_funcionalidade #(
  parameter int TIMEOUT = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       LOAD,
  input  logic [2:0] CF,
  input  logic       DONE,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       D,
  output logic       E,
  output logic       F,
  output logic       G,
  output logic       BUSY,
  output logic       ACK,
  output logic       ERR
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [6:0] sel;  // {A..G}; doubles as the latched code in one-hot form

  function automatic logic [6:0] decode(input logic [2:0] c);
    case (c)
      3'b100:  decode = 7'b1000000;
      3'b010:  decode = 7'b0100000;
      3'b110:  decode = 7'b0010000;
      3'b001:  decode = 7'b0001000;
      3'b101:  decode = 7'b0000100;
      3'b011:  decode = 7'b0000010;
      3'b111:  decode = 7'b0000001;
      default: decode = 7'b0000000;
    endcase
  endfunction

`ifdef DECOD_FUNC_TIMEOUT_EN
  logic [7:0] cnt;
`else
  logic unused_timeout;
  assign unused_timeout = ^TO_LAST;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sel   <= 7'b0;
      BUSY  <= 1'b0;
      ACK   <= 1'b0;
      ERR   <= 1'b0;
`ifdef DECOD_FUNC_TIMEOUT_EN
      cnt   <= 8'd0;
`endif
    end else begin
      ACK <= 1'b0;
      ERR <= 1'b0;
      case (state)
        IDLE: begin
          if (LOAD) begin
            if (CF == 3'b000) begin
              ERR <= 1'b1;
            end else begin
              state <= ACTIVE;
              sel   <= decode(CF);
              BUSY  <= 1'b1;
              ACK   <= 1'b1;
`ifdef DECOD_FUNC_TIMEOUT_EN
              cnt   <= 8'd0;
`endif
            end
          end
        end
        ACTIVE: begin
          // DONE has priority over a simultaneous watchdog expiry
          if (DONE) begin
            state <= IDLE;
            sel   <= 7'b0;
            BUSY  <= 1'b0;
          end
`ifdef DECOD_FUNC_TIMEOUT_EN
          else if (cnt == TO_LAST) begin
            state <= IDLE;
            sel   <= 7'b0;
            BUSY  <= 1'b0;
            ERR   <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
`endif
        end
        default: begin
          state <= IDLE;
          sel   <= 7'b0;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

  assign {A, B, C, D, E, F, G} = sel;

endmodule

// File: tb/tb_circuito_decodificador_funcionalidade.sv
// Bench for circuito_decodificador_funcionalidade: directed scenarios plus random traffic against a behavioural model.
module tb_circuito_decodificador_funcionalidade;

  localparam int TO = 4;
`ifdef DECOD_FUNC_TIMEOUT_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, LOAD, DONE;
  logic [2:0] CF;
  logic A, B, C, D, E, F, G, BUSY, ACK, ERR;

  int n_cmp = 0;
  int n_fail = 0;

  circuito_decodificador_funcionalidade #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .LOAD(LOAD), .CF(CF), .DONE(DONE),
    .A(A), .B(B), .C(C), .D(D), .E(E), .F(F), .G(G),
    .BUSY(BUSY), .ACK(ACK), .ERR(ERR)
  );

  always #5 clk = ~clk;

  // Line index 0..6 = A..G; code table straight from the code map.
  function automatic int line_of(input logic [2:0] c);
    logic [2:0] codes [7];
    codes = '{3'b100, 3'b010, 3'b110, 3'b001, 3'b101, 3'b011, 3'b111};
    line_of = -1;
    for (int i = 0; i < 7; i++) if (codes[i] == c) line_of = i;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: m_age counts cycles the selected line has been high.
  bit m_en = 1'b0;
  bit m_active = 1'b0;
  int m_line = 0;
  int m_age = 0;
  bit m_ack = 1'b0;
  bit m_err = 1'b0;

  always @(posedge clk) begin
    m_ack <= 1'b0;
    m_err <= 1'b0;
    if (rst) begin
      m_active <= 1'b0;
      m_age    <= 0;
    end else if (!m_active) begin
      if (LOAD) begin
        if (line_of(CF) < 0) m_err <= 1'b1;
        else begin
          m_active <= 1'b1;
          m_line   <= line_of(CF);
          m_ack    <= 1'b1;
          m_age    <= 1;
        end
      end
    end else begin
      if (DONE) m_active <= 1'b0;
      else if (WD_EN && m_age == TO) begin
        m_active <= 1'b0;
        m_err    <= 1'b1;
      end else m_age <= m_age + 1;
    end
  end

  function automatic logic [6:0] exp_lines();
    exp_lines = m_active ? (7'b1000000 >> m_line) : 7'b0;
  endfunction

  always @(negedge clk) begin
    if (m_en) begin
      check("lines", {25'd0, A, B, C, D, E, F, G}, {25'd0, exp_lines()});
      check("busy", {31'd0, BUSY}, {31'd0, m_active});
      check("ack", {31'd0, ACK}, {31'd0, m_ack});
      check("err", {31'd0, ERR}, {31'd0, m_err});
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [6:0] outs();
    outs = {A, B, C, D, E, F, G};
  endfunction

  initial begin
    int hi, errs;
    logic [6:0] sweep_exp [7];
    logic [2:0] sweep_cf [7];
    sweep_exp = '{7'b1000000, 7'b0100000, 7'b0010000, 7'b0001000, 7'b0000100, 7'b0000010, 7'b0000001};
    sweep_cf  = '{3'b100, 3'b010, 3'b110, 3'b001, 3'b101, 3'b011, 3'b111};

    rst = 1'b1; LOAD = 1'b0; DONE = 1'b0; CF = 3'b000;
    step(); step();
    m_en = 1'b1;
    check("reset_outs", {22'd0, outs(), BUSY, ACK, ERR}, 32'd0);
    rst = 1'b0;
    step();

    // accept 110 -> C, release after 5 cycles
    LOAD = 1'b1; CF = 3'b110;
    step();
    LOAD = 1'b0; CF = 3'b000;
    check("acc_C_lines", {25'd0, outs()}, 32'h10);
    check("acc_C_busy_ack", {30'd0, BUSY, ACK}, 32'd3);
    check("model_line_C", line_of(3'b110), 2);
    check("model_exp_C", {25'd0, exp_lines()}, 32'h10);
    step();
    check("ack_fall", {31'd0, ACK}, 32'd0);
    repeat (3) step();
    DONE = 1'b1;
    step();
    DONE = 1'b0;
    check("rel_C", {24'd0, outs(), BUSY}, 32'd0);
    step();

    for (int i = 0; i < 7; i++) begin
      LOAD = 1'b1; CF = sweep_cf[i];
      step();
      LOAD = 1'b0;
      check($sformatf("sweep%0d", i), {25'd0, outs()}, {25'd0, sweep_exp[i]});
      step();
      DONE = 1'b1;
      step();
      DONE = 1'b0;
      check($sformatf("sweep_rel%0d", i), {31'd0, BUSY}, 32'd0);
      step();
    end

    // invalid code
    LOAD = 1'b1; CF = 3'b000;
    step();
    LOAD = 1'b0;
    check("inv_err", {22'd0, outs(), BUSY, ACK, ERR}, 32'd1);
    step();
    check("inv_err_fall", {31'd0, ERR}, 32'd0);

    // LOAD ignored while ACTIVE, then reset mid-ACTIVE
    LOAD = 1'b1; CF = 3'b011;
    step();
    CF = 3'b100;
    step();
    check("ign_lines", {25'd0, outs()}, 32'h02);
    check("ign_ack_err", {30'd0, ACK, ERR}, 32'd0);
    LOAD = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid", {22'd0, outs(), BUSY, ACK, ERR}, 32'd0);
    step();

    // LOAD coinciding with DONE is dropped
    LOAD = 1'b1; CF = 3'b101;
    step();
    LOAD = 1'b1; CF = 3'b001; DONE = 1'b1;
    step();
    LOAD = 1'b0; DONE = 1'b0;
    check("load_at_done", {22'd0, outs(), BUSY, ACK, ERR}, 32'd0);
    step();

`ifdef DECOD_FUNC_TIMEOUT_EN
    LOAD = 1'b1; CF = 3'b111;
    step();
    LOAD = 1'b0;
    hi = 0; errs = 0;
    for (int i = 0; i < 10; i++) begin
      if (G) hi++;
      if (ERR) errs++;
      step();
    end
    check("wd_g_cycles", hi, TO);
    check("wd_err_pulses", errs, 1);
    LOAD = 1'b1; CF = 3'b111;
    step();
    LOAD = 1'b0;
    repeat (TO - 1) step();
    DONE = 1'b1;
    step();
    DONE = 1'b0;
    check("wd_done_wins", {30'd0, BUSY, ERR}, 32'd0);
    step();
`else
    LOAD = 1'b1; CF = 3'b001;
    step();
    LOAD = 1'b0;
    hi = 0; errs = 0;
    for (int i = 0; i < 300; i++) begin
      if (D) hi++;
      if (ERR) errs++;
      step();
    end
    check("nowd_d_cycles", hi, 300);
    check("nowd_err", errs, 0);
    DONE = 1'b1;
    step();
    DONE = 1'b0;
    check("nowd_rel", {31'd0, BUSY}, 32'd0);
    step();
`endif

    for (int i = 0; i < 2000; i++) begin
      LOAD = ($urandom_range(2) == 0);
      CF   = 3'($urandom_range(7));
      DONE = ($urandom_range(3) == 0);
      rst  = ($urandom_range(63) == 0);
      step();
    end
    rst = 1'b0; LOAD = 1'b0; DONE = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
